// File: rtl/snn_pkg.sv
// Shared fixed-point constants and small integer helpers for the spiking-network blocks.
// Width helpers are used by stdp_synapse_array and lif_neuron alike.
package snn_pkg;

  localparam int DECIMAL_BITS_DEF = 4;
  localparam int ONE              = 1 << DECIMAL_BITS_DEF;

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int trace_width(input int len);
    return $clog2(len + 1);
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int clamp(input int v, input int lo, input int hi);
    return min_i(max_i(v, lo), hi);
  endfunction

endpackage

// File: rtl/stdp_synapse_array_trace.sv
// Saturating spike trace: reloads to TRACE_LEN on a spike, otherwise counts down to 0.
// The active flag marks the pairing window of the last spike.
module stdp_trace
  import snn_pkg::*;
#(
  parameter int TRACE_LEN = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic spike,
  output logic active
);

  localparam int TW = trace_width(TRACE_LEN);

  logic [TW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (spike)
      count <= TW'(TRACE_LEN);
    else if (count != '0)
      count <= count - TW'(1);
  end

  assign active = (count != '0);

endmodule

// File: rtl/stdp_synapse_array.sv
// N_CH-input plastic synapse bank with pair-based STDP, a saturated summed current
// and a host weight write/readback port.
module stdp_synapse_array
  import snn_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int WIDTH        = 8,
  parameter int DECIMAL_BITS = DECIMAL_BITS_DEF,
  parameter int TRACE_LEN    = 16,
  parameter int A_PLUS       = 4,
  parameter int A_MINUS      = 4,
  parameter int W_MIN        = 4,
  parameter int W_MAX        = 127,
  parameter int W_INIT       = 1 << DECIMAL_BITS,
  localparam int ADDR_W      = addr_width(N_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              learn_en,
  input  logic [N_CH-1:0]   pre_spike,
  input  logic              post_spike,
  output logic [WIDTH-1:0]  i_syn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int WW    = WIDTH - 1;
  localparam int SUM_W = WW + $clog2(N_CH);
  localparam int I_MAX = (1 << (WIDTH - 1)) - 1;

  logic [N_CH-1:0]          pre_act;
  logic                     post_act;
  logic [N_CH-1:0][WW-1:0]  w;
  logic [SUM_W-1:0]         sum;
  logic                     rd_ok;

  stdp_trace #(.TRACE_LEN(TRACE_LEN)) u_post_trace (
    .clk    (clk),
    .reset  (reset),
    .spike  (post_spike),
    .active (post_act)
  );

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [WW-1:0] w_q;
    logic [WW-1:0] w_up;
    logic [WW-1:0] w_dn;
    logic [WW-1:0] w_wr;
    logic          wr_hit;
    logic          ltp;
    logic          ltd;

    stdp_trace #(.TRACE_LEN(TRACE_LEN)) u_pre_trace (
      .clk    (clk),
      .reset  (reset),
      .spike  (pre_spike[k]),
      .active (pre_act[k])
    );

    // int arithmetic leaves ample headroom, so the clamps never see a wrapped value
    assign w_up   = WW'(min_i(int'(w_q) + A_PLUS, W_MAX));
    assign w_dn   = WW'(max_i(int'(w_q) - A_MINUS, W_MIN));
    assign w_wr   = WW'(clamp(int'(wr_data), W_MIN, W_MAX));
    assign wr_hit = wr_en && (wr_addr == ADDR_W'(k));
    assign ltp    = learn_en && post_spike && pre_act[k];
    assign ltd    = learn_en && pre_spike[k] && post_act;

    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        w_q <= WW'(W_INIT);
      else if (wr_hit)
        w_q <= w_wr;
      else if (ltp)
        w_q <= w_up;
      else if (ltd)
        w_q <= w_dn;
    end

    assign w[k] = w_q;
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < N_CH; k++)
      if (pre_spike[k])
        sum = sum + SUM_W'(w[k]);
  end

  assign rd_ok = ({1'b0, rd_addr} < (ADDR_W + 1)'(N_CH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_syn   <= '0;
      rd_data <= '0;
    end else begin
      i_syn   <= WIDTH'(min_i(int'(sum), I_MAX));
      rd_data <= rd_ok ? WIDTH'(w[rd_addr]) : '0;
    end
  end

endmodule
